// File: rtl/spi_xfer_engine.sv
// SPI master transfer engine: multi-word bursts over standard/dual/quad lanes with a
// programmable SCK divider and valid/ready back-pressure on both word streams.
module spi_xfer_engine #(
   parameter int unsigned NSS_NUM    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned TRL_WIDTH  = 8,
   parameter int unsigned DIV_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DIV_WIDTH-1:0]  div_i,
   input  logic [NSS_NUM-1:0]    nss_i,
   input  logic [NSS_NUM-1:0]    csv_i,
   input  logic                  ass_i,
   input  logic                  lsb_i,
   input  logic [1:0]            mode_i,
   input  logic                  rwm_i,
   input  logic                  cpol_i,
   input  logic                  cpha_i,
   input  logic [TRL_WIDTH-1:0]  trl_i,
   input  logic                  st_i,
   output logic                  busy_o,
   output logic                  last_o,
   output logic                  done_o,
   input  logic                  tx_valid_i,
   output logic                  tx_ready_o,
   input  logic [DATA_WIDTH-1:0] tx_data_i,
   output logic                  rx_valid_o,
   input  logic                  rx_ready_i,
   output logic [DATA_WIDTH-1:0] rx_data_o,
   output logic                  spi_sck_o,
   output logic [NSS_NUM-1:0]    spi_nss_o,
   output logic [3:0]            spi_io_en_o,
   input  logic [3:0]            spi_io_in_i,
   output logic [3:0]            spi_io_out_o
);

   localparam int unsigned EcW = $clog2(2 * DATA_WIDTH);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StShift,
      StRxWait,
      StDone
   } state_e;

   state_e                state_q, state_d;
   logic [1:0]            mode_q, mode_d;
   logic                  rwm_q, rwm_d;
   logic                  lsb_q, lsb_d;
   logic                  cpol_q, cpol_d;
   logic                  cpha_q, cpha_d;
   logic [DIV_WIDTH-1:0]  div_q, div_d;
   logic [TRL_WIDTH-1:0]  trl_q, trl_d;
   logic [TRL_WIDTH-1:0]  word_q, word_d;
   logic [EcW-1:0]        edge_q, edge_d;
   logic [DIV_WIDTH-1:0]  dcnt_q, dcnt_d;
   logic                  sck_q, sck_d;
   logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
   logic [3:0]            out_q, out_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;

   logic                  dual_m, quad_m, wide_m;
   logic                  tx_need, rx_keep;
   logic [EcW-1:0]        last_edge;
   logic                  tick, do_sample;
   logic [DATA_WIDTH-1:0] load_word;
   logic [NSS_NUM-1:0]    nss_sel;

   // LSB-first is handled as MSB-first on the bit-reversed word.
   function automatic logic [DATA_WIDTH-1:0] bit_rev(input logic [DATA_WIDTH-1:0] v);
      logic [DATA_WIDTH-1:0] r;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         r[i] = v[DATA_WIDTH-1-i];
      end
      return r;
   endfunction

   function automatic logic [3:0] lane_chunk(input logic [DATA_WIDTH-1:0] sh,
                                             input logic d, input logic q);
      logic [3:0] c;
      if (q) begin
         c = sh[DATA_WIDTH-1 -: 4];
      end else if (d) begin
         c = {2'b00, sh[DATA_WIDTH-1 -: 2]};
      end else begin
         c = {3'b000, sh[DATA_WIDTH-1]};
      end
      return c;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] lane_shift(input logic [DATA_WIDTH-1:0] sh,
                                                        input logic d, input logic q);
      logic [DATA_WIDTH-1:0] s;
      if (q) begin
         s = {sh[DATA_WIDTH-5:0], 4'b0000};
      end else if (d) begin
         s = {sh[DATA_WIDTH-3:0], 2'b00};
      end else begin
         s = {sh[DATA_WIDTH-2:0], 1'b0};
      end
      return s;
   endfunction

   assign dual_m  = (mode_q == 2'd1);
   assign quad_m  = (mode_q == 2'd2);
   assign wide_m  = dual_m | quad_m;
   assign tx_need = ~(wide_m & rwm_q);
   // Dual/quad write is transmit-only, so its RX word is dropped.
   assign rx_keep = ~wide_m | rwm_q;

   always_comb begin
      if (quad_m) begin
         last_edge = EcW'(2 * DATA_WIDTH / 4 - 1);
      end else if (dual_m) begin
         last_edge = EcW'(DATA_WIDTH - 1);
      end else begin
         last_edge = EcW'(2 * DATA_WIDTH - 1);
      end
   end

   assign tick      = (dcnt_q == div_q);
   // Even edges are leading; CPHA=0 samples there, CPHA=1 samples on trailing edges.
   assign do_sample = ~edge_q[0] ^ cpha_q;
   assign load_word = tx_need ? tx_data_i : '0;

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      rwm_d      = rwm_q;
      lsb_d      = lsb_q;
      cpol_d     = cpol_q;
      cpha_d     = cpha_q;
      div_d      = div_q;
      trl_d      = trl_q;
      word_d     = word_q;
      edge_d     = edge_q;
      dcnt_d     = dcnt_q;
      sck_d      = sck_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      out_d      = out_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q & ~rx_ready_i;
      tx_ready_o = 1'b0;

      unique case (state_q)
         StIdle: begin
            sck_d = cpol_i;
            if (st_i) begin
               mode_d  = mode_i;
               rwm_d   = rwm_i;
               lsb_d   = lsb_i;
               cpol_d  = cpol_i;
               cpha_d  = cpha_i;
               div_d   = div_i;
               trl_d   = trl_i;
               word_d  = '0;
               state_d = StLoad;
            end
         end

         StLoad: begin
            if (!tx_need || tx_valid_i) begin
               tx_ready_o = tx_need;
               dcnt_d     = '0;
               edge_d     = '0;
               rx_sh_d    = '0;
               if (cpha_q) begin
                  tx_sh_d = lsb_q ? bit_rev(load_word) : load_word;
                  out_d   = 4'b0000;
               end else begin
                  out_d   = lane_chunk(lsb_q ? bit_rev(load_word) : load_word, dual_m, quad_m);
                  tx_sh_d = lane_shift(lsb_q ? bit_rev(load_word) : load_word, dual_m, quad_m);
               end
               state_d = StShift;
            end
         end

         StShift: begin
            if (tick) begin
               dcnt_d = '0;
               sck_d  = ~sck_q;
               edge_d = edge_q + EcW'(1);
               if (do_sample) begin
                  if (quad_m) begin
                     rx_sh_d = {rx_sh_q[DATA_WIDTH-5:0], spi_io_in_i[3:0]};
                  end else if (dual_m) begin
                     rx_sh_d = {rx_sh_q[DATA_WIDTH-3:0], spi_io_in_i[1:0]};
                  end else begin
                     rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], spi_io_in_i[1]};
                  end
               end else begin
                  out_d   = lane_chunk(tx_sh_q, dual_m, quad_m);
                  tx_sh_d = lane_shift(tx_sh_q, dual_m, quad_m);
               end
               if (edge_q == last_edge) begin
                  state_d = StRxWait;
               end
            end else begin
               dcnt_d = dcnt_q + DIV_WIDTH'(1);
            end
         end

         StRxWait: begin
            // Hold SCK idle until the previous RX word has been taken.
            if (!(rx_keep && rx_valid_q && !rx_ready_i)) begin
               if (rx_keep) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = lsb_q ? bit_rev(rx_sh_q) : rx_sh_q;
               end
               if (word_q == trl_q) begin
                  state_d = StDone;
               end else begin
                  word_d  = word_q + TRL_WIDTH'(1);
                  state_d = StLoad;
               end
            end
         end

         StDone: begin
            sck_d   = cpol_q;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         mode_q     <= 2'd0;
         rwm_q      <= 1'b0;
         lsb_q      <= 1'b0;
         cpol_q     <= 1'b0;
         cpha_q     <= 1'b0;
         div_q      <= '0;
         trl_q      <= '0;
         word_q     <= '0;
         edge_q     <= '0;
         dcnt_q     <= '0;
         sck_q      <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         out_q      <= 4'b0000;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         rwm_q      <= rwm_d;
         lsb_q      <= lsb_d;
         cpol_q     <= cpol_d;
         cpha_q     <= cpha_d;
         div_q      <= div_d;
         trl_q      <= trl_d;
         word_q     <= word_d;
         edge_q     <= edge_d;
         dcnt_q     <= dcnt_d;
         sck_q      <= sck_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         out_q      <= out_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   assign busy_o     = (state_q == StLoad) || (state_q == StShift) || (state_q == StRxWait);
   assign done_o     = (state_q == StDone);
   assign last_o     = busy_o && (word_q == trl_q);
   assign rx_valid_o = rx_valid_q;
   assign rx_data_o  = rx_data_q;
   assign spi_sck_o  = sck_q;

   always_comb begin
      spi_io_en_o = 4'b0000;
      if (busy_o) begin
         if (!wide_m) begin
            spi_io_en_o = 4'b0001;
         end else if (!rwm_q) begin
            spi_io_en_o = quad_m ? 4'b1111 : 4'b0011;
         end
      end
   end

   assign spi_io_out_o = busy_o ? out_q : 4'b0000;

   // nss_i, csv_i and ass_i act live, even mid-burst.
   assign nss_sel   = ass_i ? (nss_i & {NSS_NUM{busy_o}}) : nss_i;
   assign spi_nss_o = ~(nss_sel ^ csv_i);

endmodule

// File: tb/tb_spi_xfer_engine.sv
// Directed bench for spi_xfer_engine: SPI modes, lane modes, bursts, stalls and reset.
module tb_spi_xfer_engine;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [15:0] div_i;
   logic [3:0]  nss_i, csv_i;
   logic        ass_i, lsb_i, rwm_i, cpol_i, cpha_i, st_i;
   logic [1:0]  mode_i;
   logic [7:0]  trl_i;
   logic        busy_o, last_o, done_o;
   logic        tx_valid_i, tx_ready_o;
   logic [31:0] tx_data_i;
   logic        rx_valid_o, rx_ready_i;
   logic [31:0] rx_data_o;
   logic        spi_sck_o;
   logic [3:0]  spi_nss_o, spi_io_en_o, spi_io_in_i, spi_io_out_o;

   logic        loop_en;
   logic [3:0]  io_drv;
   logic [31:0] tx_mem [0:3];
   int          tx_base = 0, tx_num = 0;
   int          tx_acc = 0, rx_acc = 0, rise_cnt = 0, hi_cnt = 0, done_cnt = 0;
   int          rise_mark = 0, ones_after = 0;
   logic        first_bit = 1'b0;
   logic        sck_prev = 1'b0;
   logic [31:0] rx_log [0:15];
   logic        last_log [0:15];
   int          checks = 0, errors = 0;
   int          m_rise, m_hi, m_done, m_rx, m_ones;

   always #5 clk = ~clk;

   assign tx_valid_i  = (tx_acc - tx_base) < tx_num;
   assign tx_data_i   = tx_mem[2'(tx_acc - tx_base)];
   assign spi_io_in_i = loop_en ? {2'b00, spi_io_out_o[0], 1'b0} : io_drv;

   spi_xfer_engine dut (
      .clk_i(clk), .rst_i(rst_i), .div_i(div_i), .nss_i(nss_i), .csv_i(csv_i),
      .ass_i(ass_i), .lsb_i(lsb_i), .mode_i(mode_i), .rwm_i(rwm_i), .cpol_i(cpol_i),
      .cpha_i(cpha_i), .trl_i(trl_i), .st_i(st_i), .busy_o(busy_o), .last_o(last_o),
      .done_o(done_o), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .tx_data_i(tx_data_i), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .rx_data_o(rx_data_o), .spi_sck_o(spi_sck_o), .spi_nss_o(spi_nss_o),
      .spi_io_en_o(spi_io_en_o), .spi_io_in_i(spi_io_in_i), .spi_io_out_o(spi_io_out_o)
   );

   always @(posedge clk) begin
      sck_prev <= spi_sck_o;
      if (spi_sck_o) hi_cnt <= hi_cnt + 1;
      if (done_o) done_cnt <= done_cnt + 1;
      if (spi_sck_o && !sck_prev) begin
         rise_cnt <= rise_cnt + 1;
         if (rise_cnt == rise_mark) first_bit <= spi_io_out_o[0];
         else if (rise_cnt > rise_mark) ones_after <= ones_after + int'(spi_io_out_o[0]);
      end
      if (tx_valid_i && tx_ready_o) begin
         last_log[4'(tx_acc)] <= last_o;
         tx_acc <= tx_acc + 1;
      end
      if (rx_valid_o && rx_ready_i) begin
         rx_log[4'(rx_acc)] <= rx_data_o;
         rx_acc <= rx_acc + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic start();
      @(posedge clk);
      #1 st_i = 1'b1;
      @(posedge clk);
      #1 st_i = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk);
         #1;
         if (done_o) seen = 1'b1;
      end
      chk(tag, 32'(seen), 32'd1);
   endtask

   task automatic load_tx(input int n);
      tx_num  = 0;
      tx_base = tx_acc;
      tx_num  = n;
   endtask

   task automatic marks();
      m_rise = rise_cnt; m_hi = hi_cnt; m_done = done_cnt; m_rx = rx_acc; m_ones = ones_after;
      rise_mark = rise_cnt;
   endtask

   initial begin
      rst_i = 1'b1; div_i = 16'd1; nss_i = 4'b0001; csv_i = 4'b0000; ass_i = 1'b1;
      lsb_i = 1'b0; mode_i = 2'd0; rwm_i = 1'b0; cpol_i = 1'b0; cpha_i = 1'b0;
      trl_i = 8'd0; st_i = 1'b0; rx_ready_i = 1'b1; loop_en = 1'b1; io_drv = 4'h0;
      for (int i = 0; i < 4; i++) tx_mem[i] = 32'h0;
      cyc(3);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_outs", {24'd0, spi_sck_o, done_o, last_o, rx_valid_o, spi_io_en_o}, 32'd0);
      chk("rst_nss", 32'(spi_nss_o), 32'hF);
      rst_i = 1'b0;
      cyc(2);
      chk("idle_sck", 32'(spi_sck_o), 32'd0);

      // SPI mode 0, standard, clk/4, loopback
      tx_mem[0] = 32'hA5A5_0F0F;
      load_tx(1);
      marks();
      start();
      chk("m0_busy", 32'(busy_o), 32'd1);
      chk("m0_nss_sel", 32'(spi_nss_o), 32'hE);
      chk("m0_io_en", 32'(spi_io_en_o), 32'h1);
      wait_done(400, "m0_done");
      chk("m0_nss_desel", 32'(spi_nss_o), 32'hF);
      cyc(3);
      chk("m0_rises", 32'(rise_cnt - m_rise), 32'd32);
      chk("m0_hi_cycles", 32'(hi_cnt - m_hi), 32'd64);
      chk("m0_done_once", 32'(done_cnt - m_done), 32'd1);
      chk("m0_rx_cnt", 32'(rx_acc - m_rx), 32'd1);
      chk("m0_rx_data", rx_log[4'(m_rx)], 32'hA5A5_0F0F);

      // SPI mode 3, LSB first
      cpol_i = 1'b1; cpha_i = 1'b1; lsb_i = 1'b1; div_i = 16'd0;
      cyc(3);
      chk("m3_idle_hi_pre", 32'(spi_sck_o), 32'd1);
      tx_mem[0] = 32'h0000_0001;
      load_tx(1);
      marks();
      start();
      wait_done(300, "m3_done");
      cyc(3);
      chk("m3_sck_idle_post", 32'(spi_sck_o), 32'd1);
      chk("m3_rises", 32'(rise_cnt - m_rise), 32'd32);
      chk("m3_first_bit", 32'(first_bit), 32'd1);
      chk("m3_later_bits", 32'(ones_after - m_ones), 32'd0);
      chk("m3_rx_data", rx_log[4'(m_rx)], 32'h0000_0001);
      cpol_i = 1'b0; cpha_i = 1'b0; lsb_i = 1'b0;
      cyc(3);

      // Quad write burst of three words
      mode_i = 2'd2; rwm_i = 1'b0; trl_i = 8'd2;
      tx_mem[0] = 32'h1111_2222; tx_mem[1] = 32'h3333_4444; tx_mem[2] = 32'h5555_6666;
      load_tx(3);
      marks();
      start();
      chk("qw_io_en", 32'(spi_io_en_o), 32'hF);
      wait_done(300, "qw_done");
      cyc(3);
      chk("qw_rises", 32'(rise_cnt - m_rise), 32'd24);
      chk("qw_words", 32'(tx_acc - tx_base), 32'd3);
      chk("qw_last", {29'd0, last_log[4'(tx_base)], last_log[4'(tx_base + 1)],
                      last_log[4'(tx_base + 2)]}, 32'b001);
      chk("qw_no_rx", 32'(rx_acc - m_rx), 32'd0);
      chk("qw_done_once", 32'(done_cnt - m_done), 32'd1);

      // Quad read with a constant lane pattern
      rwm_i = 1'b1; trl_i = 8'd0; loop_en = 1'b0; io_drv = 4'h9;
      tx_mem[0] = 32'hDEAD_BEEF;
      load_tx(1);
      marks();
      start();
      chk("qr_io_en", 32'(spi_io_en_o), 32'h0);
      chk("qr_io_out", 32'(spi_io_out_o), 32'h0);
      wait_done(300, "qr_done");
      cyc(3);
      chk("qr_rx_data", rx_log[4'(m_rx)], 32'h9999_9999);
      chk("qr_no_tx", 32'(tx_acc - tx_base), 32'd0);
      tx_num = 0;
      loop_en = 1'b1; mode_i = 2'd0; rwm_i = 1'b0;

      // RX back-pressure across a two-word burst
      trl_i = 8'd1; rx_ready_i = 1'b0;
      tx_mem[0] = 32'h1234_5678; tx_mem[1] = 32'hCAFE_F00D;
      load_tx(2);
      marks();
      start();
      cyc(250);
      chk("bp_busy", 32'(busy_o), 32'd1);
      chk("bp_no_done", 32'(done_cnt - m_done), 32'd0);
      chk("bp_rx_hold", rx_data_o, 32'h1234_5678);
      chk("bp_sck_idle", 32'(spi_sck_o), 32'd0);
      chk("bp_rises", 32'(rise_cnt - m_rise), 32'd64);
      cyc(20);
      chk("bp_frozen", 32'(rise_cnt - m_rise), 32'd64);
      rx_ready_i = 1'b1;
      wait_done(10, "bp_done");
      cyc(3);
      chk("bp_rx_w1", rx_log[4'(m_rx)], 32'h1234_5678);
      chk("bp_rx_w2", rx_log[4'(m_rx + 1)], 32'hCAFE_F00D);

      // TX starvation, then reset during shifting
      trl_i = 8'd0; div_i = 16'd1;
      load_tx(0);
      marks();
      start();
      cyc(20);
      chk("sv_busy", 32'(busy_o), 32'd1);
      chk("sv_no_sck", 32'(rise_cnt - m_rise), 32'd0);
      chk("sv_nss", 32'(spi_nss_o), 32'hE);
      tx_mem[0] = 32'hFFFF_0000;
      load_tx(1);
      cyc(20);
      chk("sv_shifting", 32'(rise_cnt != m_rise), 32'd1);
      @(posedge clk);
      #1 rst_i = 1'b1;
      cyc(1);
      chk("rr_outs", {21'd0, busy_o, spi_sck_o, done_o, last_o, rx_valid_o, tx_ready_o,
                      spi_io_en_o == 4'h0, spi_io_out_o == 4'h0}, 32'h3);
      chk("rr_rx_data", rx_data_o, 32'h0);
      chk("rr_nss", 32'(spi_nss_o), 32'hF);
      rst_i = 1'b0;
      tx_num = 0;
      cyc(20);
      chk("rr_no_done", 32'(done_cnt - m_done), 32'd0);
      chk("rr_idle", {30'd0, busy_o, spi_sck_o}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
